// File: rtl/mac_ctrl_pkg.sv
// Shared types and default widths for the mac_dot_ctrl dot-product sequencer.
package mac_ctrl_pkg;

    localparam int unsigned LEN_W_DEF = 16;
    localparam int unsigned ACC_W_DEF = 40;
    localparam int unsigned OP_W      = 16;
    localparam int unsigned PROD_W    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mac_dot_acc.sv
// Wide product accumulator with 32-bit result shaping.
// MAC_DOT_SAT_EN selects saturating result with overflow flag; otherwise the result wraps.
module mac_dot_acc
    import mac_ctrl_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [PROD_W-1:0] prod,
    output logic [31:0]       res_data,
    output logic              res_ovf
);

    logic [ACC_W-1:0] acc;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

`ifdef MAC_DOT_SAT_EN
    always_comb begin
        res_ovf  = |acc[ACC_W-1:32];
        res_data = res_ovf ? '1 : acc[31:0];
    end
`else
    always_comb begin
        res_ovf  = 1'b0;
        res_data = acc[31:0];
    end
`endif

endmodule

// File: rtl/mac_dot_ctrl.sv
// Streaming dot-product sequencer driving an external 16x16 multiplier.
// Result shaping depends on MAC_DOT_SAT_EN (see mac_dot_acc).
module mac_dot_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  start_len,
    output logic              start_ready,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              in_ready,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic [PROD_W-1:0] mul_p,
    output logic              res_valid,
    output logic [31:0]       res_data,
    output logic              res_ovf,
    input  logic              res_ready
);

    state_t           state, state_next;
    logic [LEN_W-1:0] cnt;
    logic             prod_valid;
    logic             job_load;
    logic             accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_ready = 1'b0;
        in_ready    = 1'b0;
        res_valid   = 1'b0;
        job_load    = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start) begin
                    job_load   = 1'b1;
                    state_next = (start_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    if (cnt == LEN_W'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_next = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands are zeroed whenever the next state parks the multiplier (IDLE/DONE).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            prod_valid <= 1'b0;
        end else begin
            prod_valid <= accept;
            if (job_load) begin
                cnt <= start_len;
            end else if (accept) begin
                cnt <= cnt - LEN_W'(1);
            end
            if (accept) begin
                mul_a <= in_a;
                mul_b <= in_b;
            end else if (state_next == IDLE || state_next == DONE) begin
                mul_a <= '0;
                mul_b <= '0;
            end
        end
    end

    mac_dot_acc #(
        .ACC_W (ACC_W)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (job_load),
        .en       (prod_valid),
        .prod     (mul_p),
        .res_data (res_data),
        .res_ovf  (res_ovf)
    );

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Directed self-checking bench for mac_dot_ctrl with an exact multiplier model on mul_p.
module tb_mac_dot_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] start_len;
    logic        start_ready;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_ready;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [31:0] mul_p;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ovf;
    logic        res_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mul_p = 32'(mul_a) * 32'(mul_b);

    mac_dot_ctrl #(
        .LEN_W (16),
        .ACC_W (40)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_len   (start_len),
        .start_ready (start_ready),
        .in_valid    (in_valid),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_ready    (in_ready),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_p       (mul_p),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_ovf     (res_ovf),
        .res_ready   (res_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start_ready"}, 40'(start_ready), 40'd1);
        chk({tag, "_in_ready"},    40'(in_ready),    40'd0);
        chk({tag, "_res_valid"},   40'(res_valid),   40'd0);
        chk({tag, "_res_data"},    40'(res_data),    40'd0);
        chk({tag, "_res_ovf"},     40'(res_ovf),     40'd0);
        chk({tag, "_mul_a"},       40'(mul_a),       40'd0);
        chk({tag, "_mul_b"},       40'(mul_b),       40'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_len = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; res_ready = 1'b1;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;

        // len=3: (2,3),(4,5),(6,7) -> 68
        start = 1'b1; start_len = 16'd3;
        tick();
        start = 1'b0;
        chk("t1_in_ready_run", 40'(in_ready), 40'd1);
        chk("t1_start_ready_run", 40'(start_ready), 40'd0);
        in_valid = 1'b1; in_a = 16'd2; in_b = 16'd3;
        tick();
        chk("t1_mul_a", 40'(mul_a), 40'd2);
        chk("t1_mul_b", 40'(mul_b), 40'd3);
        in_a = 16'd4; in_b = 16'd5;
        tick();
        in_a = 16'd6; in_b = 16'd7;
        tick();
        in_valid = 1'b0;
        chk("t1_in_ready_drain", 40'(in_ready), 40'd0);
        chk("t1_res_valid_drain", 40'(res_valid), 40'd0);
        chk("t1_mul_a_drain", 40'(mul_a), 40'd6);
        tick();
        chk("t1_res_valid", 40'(res_valid), 40'd1);
        chk("t1_res_data", 40'(res_data), 40'd68);
        chk("t1_res_ovf", 40'(res_ovf), 40'd0);
        chk("t1_mul_a_done", 40'(mul_a), 40'd0);
        tick();
        chk("t1_idle_start_ready", 40'(start_ready), 40'd1);
        chk("t1_idle_res_valid", 40'(res_valid), 40'd0);

        // len=0 goes straight to DONE with a zero result
        start = 1'b1; start_len = 16'd0;
        tick();
        start = 1'b0;
        chk("t2_res_valid", 40'(res_valid), 40'd1);
        chk("t2_res_data", 40'(res_data), 40'd0);
        chk("t2_in_ready", 40'(in_ready), 40'd0);
        tick();
        chk("t2_idle", 40'(start_ready), 40'd1);

        // len=4 with gapped in_valid: 1+4+9+16 = 30
        start = 1'b1; start_len = 16'd4;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            in_valid = 1'b1; in_a = 16'(j); in_b = 16'(j);
            tick();
            in_valid = 1'b0;
            if (j == 2) begin
                chk("t3_in_ready_gap", 40'(in_ready), 40'd1);
                chk("t3_mul_a_hold", 40'(mul_a), 40'd2);
            end
            tick();
        end
        chk("t3_res_valid", 40'(res_valid), 40'd1);
        chk("t3_res_data", 40'(res_data), 40'd30);
        tick();

        // len=2 of 0xFFFF*0xFFFF: sum 0x1_FFFC_0002
        start = 1'b1; start_len = 16'd2;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        chk("t4_res_valid", 40'(res_valid), 40'd1);
`ifdef MAC_DOT_SAT_EN
        chk("t4_res_data", 40'(res_data), 40'hFFFF_FFFF);
        chk("t4_res_ovf", 40'(res_ovf), 40'd1);
`else
        chk("t4_res_data", 40'(res_data), 40'hFFFC_0002);
        chk("t4_res_ovf", 40'(res_ovf), 40'd0);
`endif
        tick();

        // backpressure: len=1 (5,7) -> 35 held while res_ready=0
        res_ready = 1'b0;
        start = 1'b1; start_len = 16'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_a = 16'd5; in_b = 16'd7;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            start = (i == 1 || i == 3);
            start_len = 16'd2;
            chk("t5_hold_valid", 40'(res_valid), 40'd1);
            chk("t5_hold_data", 40'(res_data), 40'd35);
            chk("t5_hold_start_ready", 40'(start_ready), 40'd0);
            tick();
        end
        // retire together with a start request: start must not be taken
        start = 1'b1; res_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_retire_idle", 40'(start_ready), 40'd1);
        chk("t5_retire_no_run", 40'(in_ready), 40'd0);
        chk("t5_retire_valid", 40'(res_valid), 40'd0);

        // reset in the middle of a len=5 job
        start = 1'b1; start_len = 16'd5;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_a = 16'd1; in_b = 16'd2;
        tick();
        in_a = 16'd3; in_b = 16'd4;
        tick();
        rst = 1'b1;
        tick();
        chk_reset_outputs("t6_rst");
        rst = 1'b0; in_valid = 1'b0;
        start = 1'b1; start_len = 16'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_a = 16'd3; in_b = 16'd3;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t6_res_valid", 40'(res_valid), 40'd1);
        chk("t6_res_data", 40'(res_data), 40'd9);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
